// File: rtl/spi_engine_rr_arbiter_if.sv
// Stream bundle between the SPI Engine requesters (s_*) and the shared execution core (m_*).
// The master modport is the arbiter's view; slave is the surrounding fabric's view.
interface spi_engine_rr_arbiter_if #(
    parameter int NUM_OF_SLAVES = 2,
    parameter int DATA_WIDTH    = 8
);
    logic [NUM_OF_SLAVES-1:0]            s_cmd_valid;
    logic [NUM_OF_SLAVES-1:0]            s_cmd_ready;
    logic [16*NUM_OF_SLAVES-1:0]         s_cmd_data;
    logic [NUM_OF_SLAVES-1:0]            s_sdo_valid;
    logic [NUM_OF_SLAVES-1:0]            s_sdo_ready;
    logic [DATA_WIDTH*NUM_OF_SLAVES-1:0] s_sdo_data;
    logic [NUM_OF_SLAVES-1:0]            s_sdi_valid;
    logic [NUM_OF_SLAVES-1:0]            s_sdi_ready;
    logic [DATA_WIDTH*NUM_OF_SLAVES-1:0] s_sdi_data;
    logic [NUM_OF_SLAVES-1:0]            s_sync_valid;
    logic [NUM_OF_SLAVES-1:0]            s_sync_ready;
    logic [8*NUM_OF_SLAVES-1:0]          s_sync;

    logic                  m_cmd_valid;
    logic                  m_cmd_ready;
    logic [15:0]           m_cmd_data;
    logic                  m_sdo_valid;
    logic                  m_sdo_ready;
    logic [DATA_WIDTH-1:0] m_sdo_data;
    logic                  m_sdi_valid;
    logic                  m_sdi_ready;
    logic [DATA_WIDTH-1:0] m_sdi_data;
    logic                  m_sync_valid;
    logic                  m_sync_ready;
    logic [7:0]            m_sync_data;

    modport master (
        input  s_cmd_valid, s_cmd_data, s_sdo_valid, s_sdo_data, s_sdi_ready, s_sync_ready,
        output s_cmd_ready, s_sdo_ready, s_sdi_valid, s_sdi_data, s_sync_valid, s_sync,
        output m_cmd_valid, m_cmd_data, m_sdo_valid, m_sdo_data, m_sdi_ready, m_sync_ready,
        input  m_cmd_ready, m_sdo_ready, m_sdi_valid, m_sdi_data, m_sync_valid, m_sync_data
    );

    modport slave (
        output s_cmd_valid, s_cmd_data, s_sdo_valid, s_sdo_data, s_sdi_ready, s_sync_ready,
        input  s_cmd_ready, s_sdo_ready, s_sdi_valid, s_sdi_data, s_sync_valid, s_sync,
        input  m_cmd_valid, m_cmd_data, m_sdo_valid, m_sdo_data, m_sdi_ready, m_sync_ready,
        output m_cmd_ready, m_sdo_ready, m_sdi_valid, m_sdi_data, m_sync_valid, m_sync_data
    );
endinterface

// File: rtl/spi_engine_rr_arbiter.sv
// Round-robin arbiter sharing one SPI Engine execution core; a grant is held for a whole
// transaction and released when the granted requester accepts sync. Includes a status watchdog.
//
// state  | meaning
// IDLE   | no grant; all valid/ready toward both sides forced low
// ACTIVE | all four streams routed between the core and requester grant_id
module spi_engine_rr_arbiter #(
    parameter int NUM_OF_SLAVES  = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           enable,
    spi_engine_rr_arbiter_if.master        bus,
    output logic                           busy,
    output logic [1:0]                     grant_id,
    output logic                           timeout
);
    localparam int          N        = NUM_OF_SLAVES;
    localparam int          DW       = DATA_WIDTH;
    localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAST_RST = 2'(N - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  last_id;
    logic [1:0]  winner;
    logic [15:0] wd_cnt;
    logic        any_hs;
    logic        release_hs;

    // Scan from farthest to nearest so the nearest requester after last_id is the final write.
    always_comb begin
        winner = last_id;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (bus.s_cmd_valid[i] && ((int'(last_id) + k) % N == i))
                    winner = 2'(i);
            end
        end
    end

    always_comb begin
        bus.m_cmd_valid  = 1'b0;
        bus.m_sdo_valid  = 1'b0;
        bus.m_sdi_ready  = 1'b0;
        bus.m_sync_ready = 1'b0;
        bus.m_cmd_data   = '0;
        bus.m_sdo_data   = '0;
        bus.s_cmd_ready  = '0;
        bus.s_sdo_ready  = '0;
        bus.s_sdi_valid  = '0;
        bus.s_sync_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == 2'(i)) begin
                bus.m_cmd_data = bus.s_cmd_data[16*i +: 16];
                bus.m_sdo_data = bus.s_sdo_data[DW*i +: DW];
                if (state == ACTIVE) begin
                    bus.m_cmd_valid     = bus.s_cmd_valid[i];
                    bus.s_cmd_ready[i]  = bus.m_cmd_ready;
                    bus.m_sdo_valid     = bus.s_sdo_valid[i];
                    bus.s_sdo_ready[i]  = bus.m_sdo_ready;
                    bus.s_sdi_valid[i]  = bus.m_sdi_valid;
                    bus.m_sdi_ready     = bus.s_sdi_ready[i];
                    bus.s_sync_valid[i] = bus.m_sync_valid;
                    bus.m_sync_ready    = bus.s_sync_ready[i];
                end
            end
        end
    end

    assign bus.s_sdi_data = {N{bus.m_sdi_data}};
    assign bus.s_sync     = {N{bus.m_sync_data}};

    assign release_hs = bus.m_sync_valid & bus.m_sync_ready;
    assign any_hs     = (bus.m_cmd_valid & bus.m_cmd_ready) | (bus.m_sdo_valid & bus.m_sdo_ready) |
                        (bus.m_sdi_valid & bus.m_sdi_ready) | release_hs;
    assign busy       = (state == ACTIVE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && (|bus.s_cmd_valid)) state_nxt = ACTIVE;
            ACTIVE:  if (release_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            grant_id <= 2'd0;
            last_id  <= LAST_RST;
            wd_cnt   <= 16'd0;
            timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == ACTIVE) begin
                grant_id <= winner;
                wd_cnt   <= 16'd0;
                timeout  <= 1'b0;
            end
            if (state == ACTIVE) begin
                if (release_hs)
                    last_id <= grant_id;
                if (WD_EN) begin
                    if (any_hs)
                        wd_cnt <= 16'd0;
                    else if (wd_cnt != 16'hFFFF)
                        wd_cnt <= wd_cnt + 16'd1;
                    if (wd_cnt == WD_LAST)
                        timeout <= 1'b1;
                end
            end
        end
    end
endmodule
